aesl_deadlock_watchdog_ctrl: RTL and testbench

Sequencing controller for the simulation-side deadlock monitor. Samples per-kernel AXI-Stream block flags and per-instance idle/block flags every cycle and qualifies a stall with a persistence timer. On timeout it latches a deadlock verdict plus a snapshot of the blocking channels, and holds both until software/testbench clears them. Sits between the kernel monitor top and the per-index deadlock monitors, replacing single-cycle combinational block decisions.

---
 rtl/aesl_deadlock_watchdog_ctrl_if.sv | 27 ++
 rtl/aesl_deadlock_watchdog_ctrl.sv | 110 +++++++++++
 tb/tb_aesl_deadlock_watchdog_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/aesl_deadlock_watchdog_ctrl_if.sv
// Handshake bundle between the kernel monitor top (master) and the deadlock watchdog (slave).
interface aesl_deadlock_watchdog_ctrl_if #(
    parameter int N_AXIS = 2,
    parameter int N_INST = 2,
    parameter int CNT_W  = 16
);
    logic              enable;
    logic              clear;
    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_INST-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic              block;
    logic              block_pulse;
    logic [N_AXIS-1:0] block_snapshot;
    logic [CNT_W-1:0]  stall_cycles;
    logic [1:0]        state;

    modport master (
        output enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_pulse, block_snapshot, stall_cycles, state
    );

    modport slave (
        input  enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_pulse, block_snapshot, stall_cycles, state
    );
endinterface

// File: rtl/aesl_deadlock_watchdog_ctrl.sv
// Deadlock watchdog: qualifies a stream/instance stall with a persistence timer and
// latches the verdict plus a snapshot of the blocking channels until cleared.
module aesl_deadlock_watchdog_ctrl #(
    parameter int                N_AXIS    = 2,
    parameter int                N_INST    = 2,
    parameter logic [N_INST-1:0] INST_MASK = 2'b01,
    parameter int                TIMEOUT   = 16,
    parameter int                CNT_W     = 16
) (
    input logic                    kernel_monitor_clock,
    input logic                    kernel_monitor_reset,
    aesl_deadlock_watchdog_ctrl_if.slave wd
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, COUNTING = 2'd2, DEADLOCK = 2'd3} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t            st;
    logic [CNT_W-1:0]  cnt;
    logic [N_AXIS-1:0] prev_blk;
    logic [N_AXIS-1:0] snap;
    logic              block_r;
    logic              pulse_r;

    logic [N_INST-1:0] inst_stalled;
    logic              stall;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    // Masked instances are tied-off slots and always count as stalled.
    for (genvar i = 0; i < N_INST; i++) begin : g_inst
        assign inst_stalled[i] = INST_MASK[i] | wd.inst_idle_sigs[i] | wd.inst_block_sigs[i];
    end

    assign stall       = (|wd.axis_block_sigs) & (&inst_stalled);
    assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign timeout_hit = (cnt_inc >= TIMEOUT_C);

    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            st       <= IDLE;
            cnt      <= '0;
            prev_blk <= '0;
            snap     <= '0;
            block_r  <= 1'b0;
            pulse_r  <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            case (st)
                IDLE: begin
                    cnt <= '0;
                    if (wd.enable) st <= ARMED;
                end
                ARMED: begin
                    if (!wd.enable) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else if (stall) begin
                        cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
                        prev_blk <= wd.axis_block_sigs;
                        if (TIMEOUT <= 1) begin
                            st      <= DEADLOCK;
                            block_r <= 1'b1;
                            pulse_r <= 1'b1;
                            snap    <= wd.axis_block_sigs;
                        end else begin
                            st <= COUNTING;
                        end
                    end
                end
                COUNTING: begin
                    if (!wd.enable) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else if (!stall) begin
                        st  <= ARMED;
                        cnt <= '0;
                    end else if (wd.axis_block_sigs != prev_blk) begin
                        // A shift in which channels block means data is still moving.
                        cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
                        prev_blk <= wd.axis_block_sigs;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            st      <= DEADLOCK;
                            block_r <= 1'b1;
                            pulse_r <= 1'b1;
                            snap    <= wd.axis_block_sigs;
                        end
                    end
                end
                DEADLOCK: begin
                    if (wd.clear) begin
                        st      <= IDLE;
                        cnt     <= '0;
                        snap    <= '0;
                        block_r <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign wd.state          = st;
    assign wd.stall_cycles   = cnt;
    assign wd.block          = block_r;
    assign wd.block_pulse    = pulse_r;
    assign wd.block_snapshot = snap;
endmodule

// File: tb/tb_aesl_deadlock_watchdog_ctrl.sv
// Bench for the deadlock watchdog: vector table, scoreboard queue, and multi-cycle sequences.
module tb_aesl_deadlock_watchdog_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aesl_deadlock_watchdog_ctrl_if #(.N_AXIS(2), .N_INST(2), .CNT_W(16)) ifc0 ();
    aesl_deadlock_watchdog_ctrl_if #(.N_AXIS(2), .N_INST(2), .CNT_W(16)) ifc1 ();

    aesl_deadlock_watchdog_ctrl #(.N_AXIS(2), .N_INST(2), .INST_MASK(2'b01), .TIMEOUT(16), .CNT_W(16)) dut0 (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .wd(ifc0.slave));
    aesl_deadlock_watchdog_ctrl #(.N_AXIS(2), .N_INST(2), .INST_MASK(2'b01), .TIMEOUT(1), .CNT_W(16)) dut1 (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .wd(ifc1.slave));

    // The TIMEOUT=1 instance sees the same stimulus.
    assign ifc1.enable          = ifc0.enable;
    assign ifc1.clear           = ifc0.clear;
    assign ifc1.axis_block_sigs = ifc0.axis_block_sigs;
    assign ifc1.inst_idle_sigs  = ifc0.inst_idle_sigs;
    assign ifc1.inst_block_sigs = ifc0.inst_block_sigs;

    typedef struct {
        logic        rst, en, clr;
        logic [1:0]  axis, idle, blk;
        logic        e_block, e_pulse;
        logic [1:0]  e_snap;
        logic [15:0] e_cnt;
        logic [1:0]  e_st;
    } vec_t;

    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic en, input logic clr,
                                input logic [1:0] axis, input logic [1:0] idle, input logic [1:0] blk,
                                input logic eb, input logic ep, input logic [1:0] es,
                                input logic [15:0] ec, input logic [1:0] est);
        vec_t v;
        v.rst = r; v.en = en; v.clr = clr; v.axis = axis; v.idle = idle; v.blk = blk;
        v.e_block = eb; v.e_pulse = ep; v.e_snap = es; v.e_cnt = ec; v.e_st = est;
        return v;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        rst                  = v.rst;
        ifc0.enable          = v.en;
        ifc0.clear           = v.clr;
        ifc0.axis_block_sigs = v.axis;
        ifc0.inst_idle_sigs  = v.idle;
        ifc0.inst_block_sigs = v.blk;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".state"}, 32'(ifc0.state), 32'(e.e_st));
        chk({tag, ".block"}, 32'(ifc0.block), 32'(e.e_block));
        chk({tag, ".pulse"}, 32'(ifc0.block_pulse), 32'(e.e_pulse));
        chk({tag, ".snap"},  32'(ifc0.block_snapshot), 32'(e.e_snap));
        chk({tag, ".cnt"},   32'(ifc0.stall_cycles), 32'(e.e_cnt));
    endtask

    task automatic cyc(input string tag, input logic en, input logic clr,
                       input logic [1:0] axis, input logic [1:0] idle, input logic [1:0] blk,
                       input logic eb, input logic ep, input logic [1:0] es,
                       input logic [15:0] ec, input logic [1:0] est);
        apply(tag, mk(1'b0, en, clr, axis, idle, blk, eb, ep, es, ec, est));
    endtask

    task automatic do_reset(input string tag, input logic en, input logic [1:0] axis, input logic [1:0] idle);
        apply(tag, mk(1'b1, en, 1'b0, axis, idle, 2'b00, 1'b0, 1'b0, 2'b00, 16'd0, 2'd0));
    endtask

    // Stall held with a fixed pattern; counter expected to walk lo..hi, deadlock at 16.
    task automatic run_stall(input string tag, input logic [1:0] axis, input logic [1:0] idle,
                             input logic [1:0] blk, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            if (k == 16) cyc(tag, 1'b1, 1'b0, axis, idle, blk, 1'b1, 1'b1, axis, 16'd16, 2'd3);
            else         cyc(tag, 1'b1, 1'b0, axis, idle, blk, 1'b0, 1'b0, 2'b00, 16'(k), 2'd2);
        end
    endtask

    task automatic clear_all(input string tag);
        cyc(tag, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 16'd0, 2'd0);
    endtask

    vec_t tbl[6];

    initial begin
        ifc0.enable = 1'b0; ifc0.clear = 1'b0;
        ifc0.axis_block_sigs = '0; ifc0.inst_idle_sigs = '0; ifc0.inst_block_sigs = '0;

        tbl[0] = mk(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);
        tbl[1] = mk(1, 1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);
        tbl[2] = mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);
        tbl[3] = mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);
        tbl[4] = mk(0, 1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        tbl[5] = mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);
        for (int i = 0; i < 6; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        // Basic timeout, then hold and ignore inputs in DEADLOCK, then clear.
        cyc("t1arm", 1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        run_stall("t1", 2'b01, 2'b10, 2'b00, 1, 16);
        cyc("t1hold", 1, 0, 2'b01, 2'b10, 2'b00, 1, 0, 2'b01, 16'd16, 2'd3);
        cyc("t4ign", 0, 0, 2'b10, 2'b00, 2'b00, 1, 0, 2'b01, 16'd16, 2'd3);
        clear_all("t4clr");
        clear_all("t4idle");

        // Progress mid-stall drops the count; a full fresh run is required.
        cyc("t2arm", 1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        run_stall("t2a", 2'b01, 2'b10, 2'b00, 1, 10);
        cyc("t2prog", 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        run_stall("t2b", 2'b01, 2'b10, 2'b00, 1, 16);
        clear_all("t2clr");

        // Pattern change restarts the count; snapshot holds the new pattern.
        cyc("t3arm", 1, 0, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, 16'd0, 2'd1);
        run_stall("t3a", 2'b01, 2'b00, 2'b10, 1, 8);
        run_stall("t3b", 2'b10, 2'b00, 2'b10, 1, 16);
        clear_all("t3clr");

        // Reset during COUNTING and during DEADLOCK.
        cyc("t5arm", 1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        run_stall("t5a", 2'b01, 2'b10, 2'b00, 1, 12);
        do_reset("t5arst", 1'b1, 2'b01, 2'b10);
        cyc("t5apost", 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);
        cyc("t5barm", 1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        run_stall("t5b", 2'b01, 2'b10, 2'b00, 1, 16);
        do_reset("t5brst", 1'b1, 2'b01, 2'b10);
        cyc("t5bpost", 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);

        // Disable on the would-be timeout cycle wins.
        cyc("t6barm", 1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        run_stall("t6b", 2'b01, 2'b10, 2'b00, 1, 15);
        cyc("t6boff", 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);
        cyc("t6bidle", 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd0);

        // TIMEOUT=1 instance: deadlock on the first stalled sample from ARMED.
        do_reset("t6arst", 1'b0, 2'b00, 2'b00);
        chk("t6a.rst.state", 32'(ifc1.state), 32'd0);
        chk("t6a.rst.block", 32'(ifc1.block), 32'd0);
        cyc("t6aarm", 1, 0, 2'b00, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        chk("t6a.arm.state", 32'(ifc1.state), 32'd1);
        cyc("t6anostall", 1, 0, 2'b00, 2'b10, 2'b00, 0, 0, 2'b00, 16'd0, 2'd1);
        chk("t6a.nostall.state", 32'(ifc1.state), 32'd1);
        chk("t6a.nostall.block", 32'(ifc1.block), 32'd0);
        cyc("t6astall", 1, 0, 2'b10, 2'b10, 2'b00, 0, 0, 2'b00, 16'd1, 2'd2);
        chk("t6a.hit.state", 32'(ifc1.state), 32'd3);
        chk("t6a.hit.block", 32'(ifc1.block), 32'd1);
        chk("t6a.hit.pulse", 32'(ifc1.block_pulse), 32'd1);
        chk("t6a.hit.snap",  32'(ifc1.block_snapshot), 32'd2);
        cyc("t6ahold", 1, 0, 2'b10, 2'b10, 2'b00, 0, 0, 2'b00, 16'd2, 2'd2);
        chk("t6a.hold.state", 32'(ifc1.state), 32'd3);
        chk("t6a.hold.block", 32'(ifc1.block), 32'd1);
        chk("t6a.hold.pulse", 32'(ifc1.block_pulse), 32'd0);
        cyc("t6aclr", 1, 1, 2'b10, 2'b10, 2'b00, 0, 0, 2'b00, 16'd3, 2'd2);
        chk("t6a.clr.state", 32'(ifc1.state), 32'd0);
        chk("t6a.clr.block", 32'(ifc1.block), 32'd0);
        chk("t6a.clr.snap",  32'(ifc1.block_snapshot), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
